hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline (fetch, decode, execute, memory, write-back).
- Generates register-forwarding selects, stage stall/flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers, and a data-memory wait freeze.
- Provides debug halt/single-step sequencing.
- Maintains saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- TIMEOUT, 64, maximum consecutive data-memory wait cycles before error (range 2..255).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in decode.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in execute.
- RegWriteE, ResultSrcE  in  1 each  execute-stage control; ResultSrcE=1 means load.
- PCSrcE  in  1  branch taken, resolved in execute.
- RdM, RegWriteM  in  5, 1  memory-stage destination register and write enable.
- RdW, RegWriteW  in  5, 1  write-back-stage destination register and write enable.
- dmem_req, dmem_ready  in  1 each  data-memory access in memory stage / completion.
- dbg_halt_req, dbg_step  in  1 each  level halt request / single-cycle step pulse.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- FlushD, FlushE  out  1 each  bubble the IF-ID / ID-EX registers.
- halted  out  1  state==HALT.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (rst=0): state=RUN, wait_cnt=0, counters=0, mem_timeout=0. All stall/flush/forward outputs are forced to 0 while rst=0.
- Registered elements: state, wait_cnt, counters, mem_timeout.
- Combinational: stall/flush/forward outputs, derived from the current state and inputs in the same cycle (0-cycle latency).
- Forwarding (all states):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE is identical using Rs2E. The M-stage match has priority over the W-stage match.
- freeze = dmem_req && !dmem_ready.
  - freeze forces StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0.
  - freeze dominates every other condition.
- lwStall = ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- States: RUN, HALT, STEP, ERR.
- RUN/STEP, no freeze:
  - StallF = StallD = lwStall.
  - FlushE = lwStall || PCSrcE.
  - FlushD = PCSrcE.
  - StallE = StallM = 0.
- HALT, no freeze:
  - StallF=StallD=1 and FlushE=1, so bubbles drain downstream.
  - FlushD=0, StallE=StallM=0.
- ERR:
  - StallF=StallD=StallE=StallM=1.
  - Flushes are 0.
  - Exit only by reset.
- Transitions (evaluated only when freeze=0, except timeout):
  - RUN -> HALT when dbg_halt_req=1.
  - HALT -> STEP when dbg_step=1.
  - HALT -> RUN when dbg_halt_req=0 (dbg_step ignored).
  - STEP lasts exactly one cycle, then -> HALT if dbg_halt_req=1, else -> RUN.
  - A freeze in HALT/STEP holds the state until released.
- Timeout:
  - wait_cnt increments each freeze cycle and clears when freeze=0.
  - If freeze=1 and wait_cnt==TIMEOUT-1: next state=ERR and mem_timeout=1 (sticky). This is the TIMEOUT-th consecutive wait cycle.
  - A wait of exactly TIMEOUT-1 cycles must not error.
- Counters (saturate at all-ones, no wrap):
  - stall_cnt += 1 each cycle StallF=1.
  - flush_cnt += 1 each cycle FlushD=1.
- Simultaneous events:
  - freeze and PCSrcE: flush is withheld. The branch is held in execute by StallE and flushes on the first cycle after release.
  - dbg_halt_req and lwStall: the load-use stall applies this cycle; HALT takes effect next cycle.
- Reset mid-operation: asynchronous return to reset values; no partial state is retained.

Decomposition:
- Shared package hazard_pkg:
  - state enumeration (RUN=2'd0, HALT=2'd1, STEP=2'd2, ERR=2'd3).
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - load encoding RESULT_MEM=1'b1.
- One sub-module, fwd_select: the combinational forwarding comparator, instantiated twice (operand A, operand B).
- FSM, timeout and counters stay in the top module.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=00. Then RdM=0 -> ForwardAE=01.
- Load-use: ResultSrcE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt increments by 1. RdE=0 -> no stall.
- Branch: PCSrcE=1 with freeze=0 -> FlushD=FlushE=1 same cycle; flush_cnt=1.
- Branch under freeze: PCSrcE=1 with dmem_ready=0 for 3 cycles -> all stalls 1 and flushes 0 for 3 cycles; flushes asserted in cycle 4.
- Debug: dbg_halt_req=1 -> halted=1 next cycle. One dbg_step pulse -> STEP for one cycle (StallF=0), then HALT. Drop dbg_halt_req -> RUN.
- Timeout (TIMEOUT=4): dmem_req=1, dmem_ready=0 for 3 cycles -> no error. Repeat for 4 cycles -> state=ERR and mem_timeout=1 after the 4th cycle, held until rst pulse clears it.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard / sequencing controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic RESULT_MEM = 1'b1;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Operand forwarding comparator: picks the youngest in-flight producer of one execute source.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rsE_i,
  input  logic [4:0] rdM_i,
  input  logic       regWriteM_i,
  input  logic [4:0] rdW_i,
  input  logic       regWriteW_i,
  output logic [1:0] fwd_o
);

  logic hitM;
  logic hitW;

  assign hitM = regWriteM_i && (rdM_i != 5'd0) && (rdM_i == rsE_i);
  assign hitW = regWriteW_i && (rdW_i != 5'd0) && (rdW_i == rsE_i);

  // The memory-stage result is newer, so it wins over write-back.
  always_comb begin
    fwd_o = FWD_RF;
    if (hitM) begin
      fwd_o = FWD_MEM;
    end else if (hitW) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard, debug-sequencing and memory-wait controller for the 5-stage RV32 pipeline.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

  logic       freeze;
  logic       lwStall;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  // RegWriteE is part of the execute control bundle but only loads create a use hazard here.
  logic       unusedRegWriteE;
  assign unusedRegWriteE = RegWriteE;

  assign freeze  = dmem_req && !dmem_ready;
  assign lwStall = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  fwd_select u_fwdA (
    .rsE_i       (Rs1E),
    .rdM_i       (RdM),
    .regWriteM_i (RegWriteM),
    .rdW_i       (RdW),
    .regWriteW_i (RegWriteW),
    .fwd_o       (fwdA)
  );

  fwd_select u_fwdB (
    .rsE_i       (Rs2E),
    .rdM_i       (RdM),
    .regWriteM_i (RegWriteM),
    .rdW_i       (RdW),
    .regWriteW_i (RegWriteW),
    .fwd_o       (fwdB)
  );

  // A memory wait freezes sequencing; only the timeout may move the state during one.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (freeze) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
      if (wait_q == WAIT_LAST) begin
        state_d   = ERR;
        timeout_d = 1'b1;
      end
    end else begin
      wait_d = '0;
      unique case (state_q)
        RUN:  if (dbg_halt_req) state_d = HALT;
        HALT: begin
          if (!dbg_halt_req) begin
            state_d = RUN;
          end else if (dbg_step) begin
            state_d = STEP;
          end
        end
        STEP: state_d = dbg_halt_req ? HALT : RUN;
        ERR:  state_d = ERR;
        default: state_d = ERR;
      endcase
    end
  end

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (rst) begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      if (freeze || (state_q == ERR)) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (state_q == HALT) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushE = lwStall || PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (StallF && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (FlushD && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_q     <= '0;
      timeout_q  <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stallCnt_q;
  assign flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed per-cycle vectors, expectations checked at negedge.
module tb_hazard_ctrl_unit;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, ResultSrcE, PCSrcE, RegWriteM, RegWriteW;
  logic dmem_req, dmem_ready, dbg_halt_req, dbg_step;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sF, sD, sE, sM, fD, fE, h, mt;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   vecIdx = 0;
  int   total  = 0;
  int   bad    = 0;

  hazard_ctrl_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mkExp(logic [1:0] fa, logic [1:0] fb,
                                 logic sF, logic sD, logic sE, logic sM,
                                 logic fD, logic fE, logic h, logic mt,
                                 int sc, int fc);
    exp_t e;
    e.fa = fa; e.fb = fb;
    e.sF = sF; e.sD = sD; e.sE = sE; e.sM = sM;
    e.fD = fD; e.fE = fE; e.h = h; e.mt = mt;
    e.sc = 16'(sc); e.fc = 16'(fc);
    return e;
  endfunction

  task automatic clearInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    dmem_req = 0; dmem_ready = 0; dbg_halt_req = 0; dbg_step = 0;
  endtask

  // Inputs are already set by the caller; this queues the expectation and spends one cycle.
  task automatic applyStimulus(input exp_t e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL vec%0d %s: got %0d expected %0d", idx, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput(vecIdx, "ForwardAE",   int'(ForwardAE),   int'(monExp.fa));
      checkOutput(vecIdx, "ForwardBE",   int'(ForwardBE),   int'(monExp.fb));
      checkOutput(vecIdx, "StallF",      int'(StallF),      int'(monExp.sF));
      checkOutput(vecIdx, "StallD",      int'(StallD),      int'(monExp.sD));
      checkOutput(vecIdx, "StallE",      int'(StallE),      int'(monExp.sE));
      checkOutput(vecIdx, "StallM",      int'(StallM),      int'(monExp.sM));
      checkOutput(vecIdx, "FlushD",      int'(FlushD),      int'(monExp.fD));
      checkOutput(vecIdx, "FlushE",      int'(FlushE),      int'(monExp.fE));
      checkOutput(vecIdx, "halted",      int'(halted),      int'(monExp.h));
      checkOutput(vecIdx, "mem_timeout", int'(mem_timeout), int'(monExp.mt));
      checkOutput(vecIdx, "stall_cnt",   int'(stall_cnt),   int'(monExp.sc));
      checkOutput(vecIdx, "flush_cnt",   int'(flush_cnt),   int'(monExp.fc));
      vecIdx++;
    end
  end

  initial begin
    clearInputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Under reset every steering output is forced low even with active inputs.
    PCSrcE = 1; RegWriteM = 1; RdM = 5; Rs1E = 5; dmem_req = 1;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 0,0));

    rst = 1'b1;
    clearInputs();
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 6;
    applyStimulus(mkExp(2'b10,2'b00, 0,0,0,0, 0,0, 0,0, 0,0));
    RdM = 0;
    applyStimulus(mkExp(2'b01,2'b00, 0,0,0,0, 0,0, 0,0, 0,0));
    RdM = 6;
    applyStimulus(mkExp(2'b01,2'b10, 0,0,0,0, 0,0, 0,0, 0,0));
    RegWriteM = 0; RegWriteW = 0; RdM = 5;
    applyStimulus(mkExp(2'b00,2'b00, 0,0,0,0, 0,0, 0,0, 0,0));

    // Load-use hazard, then a zero destination and a non-load producer.
    clearInputs();
    ResultSrcE = 1; RdE = 3; Rs2D = 3;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 0,0, 0,0));
    RdE = 0;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 1,0));
    ResultSrcE = 0; RdE = 3; Rs1D = 3;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 1,0));

    clearInputs();
    PCSrcE = 1;
    applyStimulus(mkExp(0,0, 0,0,0,0, 1,1, 0,0, 1,0));
    PCSrcE = 0;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 1,1));

    // Taken branch held back by a three-cycle memory wait.
    PCSrcE = 1; dmem_req = 1; dmem_ready = 0;
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 1,1));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 2,1));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 3,1));
    dmem_ready = 1;
    applyStimulus(mkExp(0,0, 0,0,0,0, 1,1, 0,0, 4,1));
    clearInputs();
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 4,2));

    // Halt request coinciding with a load-use stall, then step and resume.
    dbg_halt_req = 1; ResultSrcE = 1; RdE = 3; Rs1D = 3;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 0,0, 4,2));
    ResultSrcE = 0; RdE = 0; Rs1D = 0;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 1,0, 5,2));
    dbg_step = 1;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 1,0, 6,2));
    dbg_step = 0;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 7,2));
    PCSrcE = 1;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 1,0, 7,2));
    PCSrcE = 0; dbg_halt_req = 0;
    applyStimulus(mkExp(0,0, 1,1,0,0, 0,1, 1,0, 8,2));
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 9,2));

    // A wait one cycle short of the limit must not error.
    dmem_req = 1; dmem_ready = 0;
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 9,2));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 10,2));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 11,2));
    dmem_ready = 1;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 12,2));

    dmem_ready = 0;
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 12,2));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 13,2));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 14,2));
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,0, 15,2));
    clearInputs();
    PCSrcE = 1;
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,1, 16,2));
    PCSrcE = 0; dbg_halt_req = 1;
    applyStimulus(mkExp(0,0, 1,1,1,1, 0,0, 0,1, 17,2));

    clearInputs();
    rst = 1'b0;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    rst = 1'b1;
    applyStimulus(mkExp(0,0, 0,0,0,0, 0,0, 0,0, 0,0));

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending %0d expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
